// File: rtl/dve_err_pkg.sv
// Shared types and constants for the DVE ECC error-reporting controller.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package dve_err_pkg;

    // Source indices and sizing the log struct is built for.
    localparam int NSRC_MAX = 2;
    localparam int SRC_RTT  = 0;
    localparam int SRC_HTT  = 1;
    localparam int ERR_AW   = 20;
    localparam int ERR_SW   = (NSRC_MAX > 1) ? $clog2(NSRC_MAX) : 1;
    // Width of a per-cycle popcount over all sources (0..NSRC_MAX).
    localparam int PCW      = $clog2(NSRC_MAX + 1);

    typedef enum logic {ERR_C = 1'b0, ERR_UC = 1'b1} err_class_e;
    typedef enum logic {IDLE = 1'b0, ASSERTED = 1'b1} irq_state_e;
    typedef enum logic {CLR_IDLE = 1'b0, CLR_ACK = 1'b1} clr_state_e;

    typedef struct packed {
        logic              vld;
        logic              uc;
        logic [ERR_SW-1:0] src;
        logic [ERR_AW-1:0] addr;
    } err_log_t;

    // Interrupt state transition: a qualified, enabled event wins over a clear,
    // so an error arriving in the clear cycle keeps the interrupt raised.
    function automatic irq_state_e irq_next(input irq_state_e cur, input logic evt,
                                            input logic en, input logic clr);
        irq_state_e nxt;
        nxt = cur;
        if (evt && en) begin
            nxt = ASSERTED;
        end else if (clr) begin
            nxt = IDLE;
        end
        return nxt;
    endfunction

    // Number of set bits in a source event vector.
    function automatic logic [PCW-1:0] popcnt(input logic [NSRC_MAX-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < NSRC_MAX; i++) begin
            c = c + {{(PCW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/dve_err_sat_cnt.sv
// Saturating up-counter with variable increment and synchronous clear.
// Latency: 1 cycle from inc/clr to cnt; cnt_nxt exposes the value being loaded.
// Backpressure: none; clear and increment in one cycle yields the increment alone.
module dve_err_sat_cnt #(
    parameter int W  = 32,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [IW-1:0] inc,
    output logic [W-1:0]  cnt,
    output logic [W-1:0]  cnt_nxt
);

    logic [W-1:0] base;
    logic [W:0]   sum;

    // Clear first, then add; carry out of W bits means saturate at all-ones.
    always_comb begin
        base    = clr ? '0 : cnt;
        sum     = {1'b0, base} + {{(W + 1 - IW){1'b0}}, inc};
        cnt_nxt = sum[W] ? '1 : sum[W-1:0];
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dve_err_irq_ctrl.sv
// Error counters, first-error log and IRQ_C/IRQ_UC for the DVE ECC memories.
// Latency: error pulse at cycle N visible at N+1; clear ack one cycle after req.
// Backpressure: req while ack is pending is dropped; DVE_ERR_RESILIENCY_EN adds fault outputs.
module dve_err_irq_ctrl
    import dve_err_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int CW   = 32,
    parameter int AW   = 20
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NSRC-1:0]                       src_sbe_vld,
    input  logic [NSRC-1:0]                       src_dbe_vld,
    input  logic [NSRC*AW-1:0]                    src_err_addr,
    input  logic                                  csr_irq_c_en,
    input  logic                                  csr_irq_uc_en,
    input  logic                                  csr_clr_req,
    input  logic [1:0]                            csr_clr_sel,
    output logic                                  csr_clr_ack,
    input  logic [9:0]                            csr_cerr_threshold,
    output logic                                  irq_c,
    output logic                                  irq_uc,
    output logic [NSRC*CW-1:0]                    single_bit_count,
    output logic [NSRC*CW-1:0]                    double_bit_count,
    output logic                                  err_log_vld,
    output logic                                  err_log_uc,
    output logic [(NSRC > 1 ? $clog2(NSRC) : 1)-1:0] err_log_src,
    output logic [AW-1:0]                         err_log_addr,
    output logic [15:0]                           cerr_counter,
    output logic                                  cerr_over_thres_fault,
    output logic                                  fault_mission_fault,
    output logic                                  fault_latent_fault
);

    // A double-bit error masks a simultaneous single-bit error on that source.
    logic [NSRC-1:0] c_evt;
    logic [NSRC-1:0] uc_evt;
    assign c_evt  = src_sbe_vld & ~src_dbe_vld;
    assign uc_evt = src_dbe_vld;

    // ---------------- clear handshake ----------------
    clr_state_e clr_q, clr_d;
    logic       clr_accept;
    logic       clr_c;
    logic       clr_uc;

    // Clear FSM next state: a request is accepted only from CLR_IDLE.
    always_comb begin
        clr_d      = clr_q;
        clr_accept = 1'b0;
        case (clr_q)
            CLR_IDLE: begin
                if (csr_clr_req) begin
                    clr_d      = CLR_ACK;
                    clr_accept = 1'b1;
                end
            end
            CLR_ACK:  clr_d = CLR_IDLE;
            default:  clr_d = CLR_IDLE;
        endcase
    end

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_q <= CLR_IDLE;
        end else begin
            clr_q <= clr_d;
        end
    end

    assign clr_c       = clr_accept & csr_clr_sel[0];
    assign clr_uc      = clr_accept & csr_clr_sel[1];
    assign csr_clr_ack = (clr_q == CLR_ACK);

    // ---------------- per-source counters ----------------
    logic [CW-1:0] sb_nxt_unused [NSRC];
    logic [CW-1:0] db_nxt_unused [NSRC];

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        dve_err_sat_cnt #(.W(CW), .IW(1)) u_sb_cnt (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr_c),
            .inc     (c_evt[gi]),
            .cnt     (single_bit_count[gi*CW +: CW]),
            .cnt_nxt (sb_nxt_unused[gi])
        );
        dve_err_sat_cnt #(.W(CW), .IW(1)) u_db_cnt (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr_uc),
            .inc     (uc_evt[gi]),
            .cnt     (double_bit_count[gi*CW +: CW]),
            .cnt_nxt (db_nxt_unused[gi])
        );
    end

    // ---------------- interrupt FSMs ----------------
    irq_state_e irq_c_q, irq_c_d;
    irq_state_e irq_uc_q, irq_uc_d;

    // Interrupt FSM next state for both classes.
    always_comb begin
        irq_c_d  = irq_next(irq_c_q, |c_evt, csr_irq_c_en, clr_c);
        irq_uc_d = irq_next(irq_uc_q, |uc_evt, csr_irq_uc_en, clr_uc);
    end

    // Interrupt FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_c_q  <= IDLE;
            irq_uc_q <= IDLE;
        end else begin
            irq_c_q  <= irq_c_d;
            irq_uc_q <= irq_uc_d;
        end
    end

    // Enable masks the output only; the pending state survives a disable.
    assign irq_c  = (irq_c_q == ASSERTED) & csr_irq_c_en;
    assign irq_uc = (irq_uc_q == ASSERTED) & csr_irq_uc_en;

    // ---------------- first-error log ----------------
    err_log_t        log_q, log_d;
    logic            cand_vld;
    logic            cand_uc;
    logic [NSRC-1:0] cand_pick;
    logic [ERR_SW-1:0] cand_src;
    logic [AW-1:0]   cand_addr;
    logic            log_hit_clr;

    // Pick the capture candidate (UC first, lowest source) and update the log.
    always_comb begin
        cand_uc   = |uc_evt;
        cand_vld  = (|uc_evt) | (|c_evt);
        cand_pick = cand_uc ? uc_evt : c_evt;
        cand_src  = '0;
        cand_addr = src_err_addr[AW-1:0];
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand_pick[i]) begin
                cand_src  = i[ERR_SW-1:0];
                cand_addr = src_err_addr[i*AW +: AW];
            end
        end

        log_hit_clr = log_q.vld & (log_q.uc ? clr_uc : clr_c);
        log_d       = log_q;
        if (log_hit_clr) begin
            log_d.vld = 1'b0;
        end
        // Load into an empty log, or upgrade a correctable log to uncorrectable.
        if (cand_vld && (!log_d.vld || (cand_uc && !log_d.uc))) begin
            log_d.vld  = 1'b1;
            log_d.uc   = cand_uc;
            log_d.src  = cand_src;
            log_d.addr = cand_addr;
        end
    end

    // Log register.
    always_ff @(posedge clk) begin
        if (reset) begin
            log_q <= '0;
        end else begin
            log_q <= log_d;
        end
    end

    assign err_log_vld  = log_q.vld;
    assign err_log_uc   = log_q.uc;
    assign err_log_src  = log_q.src;
    assign err_log_addr = log_q.addr;

    // ---------------- resiliency ----------------
`ifdef DVE_ERR_RESILIENCY_EN
    logic [15:0] cerr_nxt;
    logic        over_q;

    dve_err_sat_cnt #(.W(16), .IW(PCW)) u_cerr_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_c),
        .inc     (popcnt(c_evt)),
        .cnt     (cerr_counter),
        .cnt_nxt (cerr_nxt)
    );

    // Sticky threshold fault, compared against the value being loaded so the
    // fault rises in the same cycle the counter crosses the threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            over_q <= 1'b0;
        end else begin
            over_q <= (over_q & ~clr_c) |
                      ((csr_cerr_threshold != 10'd0) && (cerr_nxt > {6'd0, csr_cerr_threshold}));
        end
    end

    assign cerr_over_thres_fault = over_q;
    assign fault_latent_fault    = over_q;
    assign fault_mission_fault   = (irq_uc_q == ASSERTED);
`else
    logic thr_unused;
    assign thr_unused            = ^csr_cerr_threshold;
    assign cerr_counter          = 16'd0;
    assign cerr_over_thres_fault = 1'b0;
    assign fault_latent_fault    = 1'b0;
    assign fault_mission_fault   = 1'b0;
`endif

endmodule
